csr_trap_ctrl: RTL

// - Trap-entry/return sequencer downstream of the CSR access check.
// - Accepts one request at a time over a valid/ready handshake. A request is either:
//   - an exception, e.g. an illegal CSR read such as SATP with TVM set below M-mode; or
//   - an MRET.
// - Owns the current privilege level and mstatus.MPP.
// - Sequences pipeline flush -> CSR trap-register write -> PC redirect.

---
 rtl/csr_trap_ctrl_pkg.sv | 42 ++++
 rtl/csr_trap_ctrl_if.sv | 54 +++++
 rtl/csr_trap_ctrl_sat_counter.sv | 24 ++
 rtl/csr_trap_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared trap-sequencer types: privilege encoding, FSM states and common
// exception cause codes.
package riscv_trap_pkg;

  // Privilege levels as encoded in mstatus.MPP and the current-mode register.
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  // Trap-entry / return sequence.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WRITE    = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  // Synchronous exception cause codes (mcause with the interrupt bit clear).
  localparam int unsigned CAUSE_INSTR_MISALIGNED = 0;
  localparam int unsigned CAUSE_INSTR_ACCESS     = 1;
  localparam int unsigned CAUSE_ILLEGAL_INSTR    = 2;
  localparam int unsigned CAUSE_BREAKPOINT       = 3;
  localparam int unsigned CAUSE_LOAD_ACCESS      = 5;
  localparam int unsigned CAUSE_STORE_ACCESS     = 7;
  localparam int unsigned CAUSE_ECALL_U          = 8;
  localparam int unsigned CAUSE_ECALL_S          = 9;
  localparam int unsigned CAUSE_ECALL_M          = 11;

  // The reserved encoding 2'b10 must never land in MPP; it collapses to U.
  function automatic priv_lvl_t legalise_mpp(input logic [1:0] i_lvl);
    priv_lvl_t w_lvl;
    case (i_lvl)
      2'b01:   w_lvl = PRIV_LVL_S;
      2'b11:   w_lvl = PRIV_LVL_M;
      default: w_lvl = PRIV_LVL_U;
    endcase
    return w_lvl;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Request, pipeline-flush, trap-CSR write, fetch-redirect and status signals
// of the trap sequencer. The slave modport is the sequencer's view.
interface csr_trap_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);

  // Request channel from the CSR access check
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_mret_i;
  logic [XLEN-1:0]  req_cause_i;
  logic [XLEN-1:0]  req_tval_i;
  logic [XLEN-1:0]  req_pc_i;

  // Current CSR contents
  logic [XLEN-1:0]  mtvec_i;
  logic [XLEN-1:0]  mepc_i;

  // Pipeline flush
  logic             flush_o;
  logic             flush_ack_i;

  // Trap CSR write port
  logic             trap_we_o;
  logic [XLEN-1:0]  mepc_o;
  logic [XLEN-1:0]  mcause_o;
  logic [XLEN-1:0]  mtval_o;

  // Fetch redirect
  logic             redirect_valid_o;
  logic             redirect_ready_i;
  logic [XLEN-1:0]  redirect_pc_o;

  // Architectural status
  logic [1:0]       priv_lvl_o;
  logic [1:0]       mpp_o;
  logic [CNT_W-1:0] trap_count_o;

  modport slave (
    input  req_valid_i, req_mret_i, req_cause_i, req_tval_i, req_pc_i,
    input  mtvec_i, mepc_i, flush_ack_i, redirect_ready_i,
    output req_ready_o, flush_o, trap_we_o, mepc_o, mcause_o, mtval_o,
    output redirect_valid_o, redirect_pc_o, priv_lvl_o, mpp_o, trap_count_o
  );

  modport master (
    output req_valid_i, req_mret_i, req_cause_i, req_tval_i, req_pc_i,
    output mtvec_i, mepc_i, flush_ack_i, redirect_ready_i,
    input  req_ready_o, flush_o, trap_we_o, mepc_o, mcause_o, mtval_o,
    input  redirect_valid_o, redirect_pc_o, priv_lvl_o, mpp_o, trap_count_o
  );

endinterface

// File: rtl/csr_trap_ctrl_sat_counter.sv
// Saturating up-counter: counts increment strobes and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] r_count;

  // Count up on each strobe until the all-ones ceiling is reached
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap-entry / MRET sequencer: flush the pipeline, write mepc/mcause/mtval
// (exceptions only), then redirect fetch. Owns the current privilege level
// and mstatus.MPP.
module csr_trap_ctrl
  import riscv_trap_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  csr_trap_ctrl_if.slave  bus
);

  // Clears the two low bits of a PC / mtvec value.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  trap_state_e      r_state;
  logic             r_req_ready;
  logic             r_mret;
  logic [XLEN-1:0]  r_cause;
  logic [XLEN-1:0]  r_tval;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_mret_tgt;
  logic             r_flush;
  logic             r_trap_we;
  logic [XLEN-1:0]  r_mepc;
  logic [XLEN-1:0]  r_mcause;
  logic [XLEN-1:0]  r_mtval;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  priv_lvl_t        r_priv;
  priv_lvl_t        r_mpp;

  logic             w_accept;
  logic             w_count_inc;
  logic [CNT_W-1:0] w_trap_count;

  // Ready is only ever high in IDLE, so this is also the IDLE accept.
  assign w_accept    = bus.req_valid_i && r_req_ready;
  // An exception is counted on the edge that leaves WRITE.
  assign w_count_inc = (r_state == ST_WRITE);

  // Sequencer FSM with registered outputs and privilege/MPP state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      r_req_ready      <= 1'b1;
      r_mret           <= 1'b0;
      r_cause          <= '0;
      r_tval           <= '0;
      r_pc             <= '0;
      r_mret_tgt       <= '0;
      r_flush          <= 1'b0;
      r_trap_we        <= 1'b0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_priv           <= PRIV_LVL_M;
      r_mpp            <= PRIV_LVL_U;
    end else begin
      // NOTE: a non-blocking default followed by a later override in the same
      // block is safe; the last scheduled update wins, giving a 1-cycle strobe.
      r_trap_we <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mret      <= bus.req_mret_i;
            r_cause     <= bus.req_cause_i;
            r_tval      <= bus.req_tval_i;
            r_pc        <= bus.req_pc_i;
            r_mret_tgt  <= bus.mepc_i;
            r_req_ready <= 1'b0;
            r_flush     <= 1'b1;
            r_state     <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (bus.flush_ack_i) begin
            r_flush <= 1'b0;
            if (r_mret) begin
              // Returns skip the CSR write and go straight to fetch.
              r_redirect_valid <= 1'b1;
              r_redirect_pc    <= r_mret_tgt;
              r_state          <= ST_REDIRECT;
            end else begin
              r_trap_we <= 1'b1;
              r_mepc    <= r_pc & ALIGN_MASK;
              r_mcause  <= r_cause;
              r_mtval   <= r_tval;
              r_state   <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          // Trap entry: remember where we came from and enter M-mode.
          // Exceptions never vector, so only the mtvec base matters.
          r_mpp            <= legalise_mpp(r_priv);
          r_priv           <= PRIV_LVL_M;
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= bus.mtvec_i & ALIGN_MASK;
          r_state          <= ST_REDIRECT;
        end

        ST_REDIRECT: begin
          if (bus.redirect_ready_i) begin
            r_redirect_valid <= 1'b0;
            r_req_ready      <= 1'b1;
            r_state          <= ST_IDLE;
            if (r_mret) begin
              r_priv <= r_mpp;
              r_mpp  <= PRIV_LVL_U;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_trap_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_count_inc),
    .count_o (w_trap_count)
  );

  assign bus.req_ready_o      = r_req_ready;
  assign bus.flush_o          = r_flush;
  assign bus.trap_we_o        = r_trap_we;
  assign bus.mepc_o           = r_mepc;
  assign bus.mcause_o         = r_mcause;
  assign bus.mtval_o          = r_mtval;
  assign bus.redirect_valid_o = r_redirect_valid;
  assign bus.redirect_pc_o    = r_redirect_pc;
  assign bus.priv_lvl_o       = r_priv;
  assign bus.mpp_o            = r_mpp;
  assign bus.trap_count_o     = w_trap_count;

endmodule
